geofence_ctrl: RTL



---
 rtl/geofence_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/geofence_ctrl.sv
// Geofence controller: loads an object point and a fence, angle-sorts the fence about F[0]
// via the external orientation unit, then edge-tests the object. Option: GEOFENCE_EARLY_EXIT_EN.
module geofence_ctrl #(
  parameter int COORD_W = 10,
  parameter int FENCE_N = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [COORD_W-1:0] X,
  input  logic [COORD_W-1:0] Y,
  output logic               busy,
  output logic [COORD_W:0]   AX,
  output logic [COORD_W:0]   AY,
  output logic [COORD_W:0]   BX,
  output logic [COORD_W:0]   BY,
  input  logic               cw,
  output logic               out_valid,
  output logic               is_inside
);

  localparam int IDX_W = $clog2(FENCE_N);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SORT = 3'd2;
  localparam logic [2:0] S_TEST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FENCE_N - 1);
  localparam logic [IDX_W-1:0] PASS_LAST = IDX_W'(FENCE_N - 3);

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   vec_t;

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d, p_q, p_d, j_q, j_d, e_q, e_d;
  coord_t           ox_q, ox_d, oy_q, oy_d;
  coord_t           fx_q [FENCE_N];
  coord_t           fx_d [FENCE_N];
  coord_t           fy_q [FENCE_N];
  coord_t           fy_d [FENCE_N];
  logic             all_cw_q, all_cw_d;
  logic             inside_q, inside_d;

  logic [IDX_W-1:0] j_nxt, j_end, e_nxt;

  // Both coordinates are zero-extended, so the difference always fits the operand width.
  function automatic vec_t sub(input coord_t a, input coord_t b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  assign j_nxt = j_q + IDX_ONE;
  assign j_end = IDX_W'(FENCE_N - 2) - p_q;
  assign e_nxt = (e_q == IDX_LAST) ? '0 : e_q + IDX_ONE;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d  = state_q;
    k_d      = k_q;
    p_d      = p_q;
    j_d      = j_q;
    e_d      = e_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    fx_d     = fx_q;
    fy_d     = fy_q;
    all_cw_d = all_cw_q;
    inside_d = inside_q;
    AX       = '0;
    AY       = '0;
    BX       = '0;
    BY       = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ox_d    = X;
          oy_d    = Y;
          k_d     = '0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (in_valid) begin
          fx_d[k_q] = X;
          fy_d[k_q] = Y;
          if (k_q == IDX_LAST) begin
            k_d     = '0;
            p_d     = '0;
            j_d     = IDX_ONE;
            state_d = S_SORT;
          end else begin
            k_d = k_q + IDX_ONE;
          end
        end
      end

      S_SORT: begin
        AX = sub(fx_q[j_q], fx_q[0]);
        AY = sub(fy_q[j_q], fy_q[0]);
        BX = sub(fx_q[j_nxt], fx_q[0]);
        BY = sub(fy_q[j_nxt], fy_q[0]);
        // Collinear pairs also swap; the comparison is strict.
        if (!cw) begin
          fx_d[j_q]   = fx_q[j_nxt];
          fy_d[j_q]   = fy_q[j_nxt];
          fx_d[j_nxt] = fx_q[j_q];
          fy_d[j_nxt] = fy_q[j_q];
        end
        if (j_q == j_end) begin
          if (p_q == PASS_LAST) begin
            e_d      = '0;
            all_cw_d = 1'b1;
            state_d  = S_TEST;
          end else begin
            p_d = p_q + IDX_ONE;
            j_d = IDX_ONE;
          end
        end else begin
          j_d = j_nxt;
        end
      end

      S_TEST: begin
        AX       = sub(fx_q[e_q], ox_q);
        AY       = sub(fy_q[e_q], oy_q);
        BX       = sub(fx_q[e_nxt], ox_q);
        BY       = sub(fy_q[e_nxt], oy_q);
        all_cw_d = all_cw_q & cw;
        if (e_q == IDX_LAST) begin
          e_d      = '0;
          inside_d = all_cw_d;
          state_d  = S_DONE;
`ifdef GEOFENCE_EARLY_EXIT_EN
        end else if (!cw) begin
          e_d      = '0;
          inside_d = 1'b0;
          state_d  = S_DONE;
`endif
        end else begin
          e_d = e_nxt;
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      p_q      <= '0;
      j_q      <= '0;
      e_q      <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      all_cw_q <= 1'b0;
      inside_q <= 1'b0;
      // NOTE: the fence array is small flop storage and must read 0 after reset, so it is cleared here.
      for (int i = 0; i < FENCE_N; i++) begin
        fx_q[i] <= '0;
        fy_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      k_q      <= k_d;
      p_q      <= p_d;
      j_q      <= j_d;
      e_q      <= e_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      all_cw_q <= all_cw_d;
      inside_q <= inside_d;
      fx_q     <= fx_d;
      fy_q     <= fy_d;
    end
  end

  assign busy      = (state_q == S_SORT) || (state_q == S_TEST) || (state_q == S_DONE);
  assign out_valid = (state_q == S_DONE);
  assign is_inside = inside_q;

endmodule
